uart_baud_ctrl: RTL and testbench
=================================

Name: uart_baud_ctrl

Overview:
- Configuration controller and tick scheduler for the UART baud path.
- Accepts a baud-rate / clock-frequency pair through a valid/ready handshake and computes a rounded oversampling divisor with a sequential restoring divider.
- Applies the new divisor only while the UART is not busy, then emits the os_tick and baud_tick enables consumed by the TX/RX engines.

Parameters:
- OSR_LOG2, 4: log2 of the oversampling ratio (default 16x).
- DIV_W, 16: integer divisor width; larger quotients are rejected.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  high only in IDLE; transfer when cfg_valid & cfg_ready.
- cfg_baud  in  32  requested baud rate in bit/s; sampled at transfer.
- cfg_clk_freq  in  32  clk frequency in Hz; sampled at transfer.
- busy_in  in  1  TX/RX frame in progress; blocks apply.
- cfg_done  out  1  one-cycle pulse when the new divisor takes effect.
- cfg_err  out  1  sticky; set on rejected config, cleared on next transfer.
- locked  out  1  a valid divisor is active and ticks are running.
- divisor  out  DIV_W  active integer divisor.
- os_tick  out  1  one-cycle oversample enable.
- baud_tick  out  1  one-cycle bit enable, coincident with every 2^OSR_LOG2-th os_tick.

Behaviour:
- Reset values: cfg_ready=1, cfg_done=0, cfg_err=0, locked=0, divisor=0, os_tick=0, baud_tick=0, FSM=IDLE, all counters 0. Reset mid-calculation aborts it with no partial update.
- Divisor formula: Q = floor((clk_freq + (baud<<(OSR_LOG2-1))) / (baud<<OSR_LOG2)). This is the rounded value of clk_freq/(baud*2^OSR_LOG2).
- Internal arithmetic is 36+OSR_LOG2 bits wide, so nothing overflows.
- FSM state IDLE: cfg_ready=1. A transfer latches both operands, clears cfg_err and goes to CALC.
- FSM state CALC: one quotient bit per cycle, fixed CALC_CYC=36+OSR_LOG2 cycles (40 at default), then CHECK.
- FSM state CHECK (1 cycle):
  - Error if baud==0, Q==0 or Q>2^DIV_W-1: set cfg_err and return to IDLE. divisor, locked and the ticks are unchanged.
  - Otherwise go to APPLY if busy_in==0, else to WAIT_IDLE.
- FSM state WAIT_IDLE: hold until busy_in==0, then APPLY. cfg_ready=0 throughout.
- FSM state APPLY (1 cycle): at the closing edge load divisor=Q, set locked=1, clear both tick counters, pulse cfg_done, return to IDLE.
- Latency with busy_in low: transfer at edge E0 gives cfg_done high in the cycle starting at edge E0+CALC_CYC+2 (E0+42 at default).
- Tick generation, only while locked:
  - os counter runs 0..divisor-1; os_tick is high when the count is divisor-1, then the count wraps to 0.
  - Counter is 0 in the cfg_done cycle, so the first os_tick comes divisor cycles after cfg_done; period is exactly divisor cycles.
  - divisor==1 gives os_tick continuously high.
  - Phase counter increments on each os_tick; baud_tick = os_tick & (phase==2^OSR_LOG2-1).
- Reconfiguration while locked: ticks continue on the old divisor through CALC/CHECK/WAIT_IDLE. Both counters restart at APPLY with no partial or doubled tick.
- cfg_valid outside IDLE is ignored (no transfer). Operand changes after the transfer do not affect the calculation in flight.

Optional Feature:
- Macro: UART_BAUD_FRAC_EN.
- When defined:
  - Numerator is pre-shifted left by 4, so Q carries 4 fractional bits and CALC_CYC increases by 4.
  - The integer part drives divisor; range checks apply to the integer part.
  - A 4-bit fractional accumulator adds frac on each os_tick; on carry-out the next os period is divisor+1 cycles.
  - The average os period equals Q/16 cycles.
- When undefined: integer divisor only, no accumulator logic, timing exactly as above.

Test Plan:
- Reset release, cfg_clk_freq=48, cfg_baud=1 -> cfg_done at E0+42; divisor=3; os_tick every 3 cycles; baud_tick every 48 cycles; locked=1.
- cfg_clk_freq=50_000_000, cfg_baud=115200 -> divisor=27. Then cfg_clk_freq=16_000_000, cfg_baud=9600 -> divisor=104, cfg_err=0.
- Rejected configs: cfg_baud=0; cfg_clk_freq=1000 with cfg_baud=115200 (Q=0); cfg_clk_freq=0xFFFFFFFF with cfg_baud=1 (Q>65535) -> each sets cfg_err=1, no cfg_done, previous divisor and ticks continue. A following valid config clears cfg_err.
- Locked at divisor=3, busy_in=1, new config for divisor=104 -> state holds WAIT_IDLE, cfg_ready=0, 3-cycle ticks continue. Drop busy_in -> cfg_done 2 cycles later, then 104-cycle os_tick period.
- Assert rst low 10 cycles into CALC -> all outputs at reset values, locked=0, no ticks. The next transfer completes normally.
- With UART_BAUD_FRAC_EN, cfg_clk_freq=50_000_000, cfg_baud=115200 -> divisor=27, frac=2. Over 16 os_ticks, 2 periods are 28 cycles and 14 are 27 cycles (434 cycles total).

Source files
------------

// File: rtl/uart_baud_ctrl.sv
// UART baud configuration controller: rounded divisor via sequential restoring divider, tick scheduler.
// Optional fractional divisor (4 fractional bits) enabled by defining UART_BAUD_FRAC_EN.
module uart_baud_ctrl #(
  parameter int OSR_LOG2 = 4,
  parameter int DIV_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [31:0]      cfg_baud,
  input  logic [31:0]      cfg_clk_freq,
  input  logic             busy_in,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             locked,
  output logic [DIV_W-1:0] divisor,
  output logic             os_tick,
  output logic             baud_tick
);

`ifdef UART_BAUD_FRAC_EN
  localparam int FRAC_W = 4;
`else
  localparam int FRAC_W = 0;
`endif
  localparam int QW       = 36 + OSR_LOG2;
  localparam int AW       = QW + FRAC_W;
  localparam int CALC_CYC = AW;
  localparam int CNT_W    = $clog2(CALC_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_CHECK,
    S_WAIT_IDLE,
    S_APPLY
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [AW-1:0]      r_num;
  logic [AW-1:0]      r_den;
  logic [AW-1:0]      r_rem;
  logic [AW-1:0]      r_quo;
  logic [CNT_W-1:0]   r_calc_cnt;
  logic               r_baud_zero;
  logic               r_cfg_err;
  logic               r_cfg_done;
  logic               r_locked;
  logic [DIV_W-1:0]   r_divisor;
  logic [DIV_W-1:0]   r_os_cnt;
  logic [OSR_LOG2-1:0] r_phase;
  logic               r_os_tick;
  logic               r_baud_tick;

  logic [AW-1:0]      w_clk_ext;
  logic [AW-1:0]      w_baud_ext;
  logic [AW-1:0]      w_num_init;
  logic [AW-1:0]      w_den_init;
  logic [AW:0]        w_trial;
  logic               w_ge;
  logic [AW-1:0]      w_diff;
  logic [QW-1:0]      w_q_int;
  logic               w_cfg_bad;
  logic               w_extend;
  logic [DIV_W-1:0]   w_os_last;
  logic               w_os_wrap;

  assign cfg_ready = (r_state == S_IDLE);
  assign cfg_done  = r_cfg_done;
  assign cfg_err   = r_cfg_err;
  assign locked    = r_locked;
  assign divisor   = r_divisor;
  assign os_tick   = r_os_tick;
  assign baud_tick = r_baud_tick;

  // Rounding term is half the denominator, added before the divide.
  assign w_clk_ext  = AW'(cfg_clk_freq);
  assign w_baud_ext = AW'(cfg_baud);
  assign w_num_init = (w_clk_ext << FRAC_W) + (w_baud_ext << (OSR_LOG2 - 1));
  assign w_den_init = w_baud_ext << OSR_LOG2;

  assign w_trial = {r_rem, r_num[AW-1]};
  assign w_ge    = (w_trial >= {1'b0, r_den});
  assign w_diff  = w_trial[AW-1:0] - r_den;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] w_q_frac;
  assign w_q_int  = r_quo[AW-1:FRAC_W];
  assign w_q_frac = r_quo[FRAC_W-1:0];
`else
  assign w_q_int  = r_quo;
`endif

  assign w_cfg_bad = r_baud_zero | (w_q_int == '0) | (|w_q_int[QW-1:DIV_W]);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (cfg_valid) w_state_nxt = S_CALC;
      S_CALC:      if (r_calc_cnt == CNT_W'(CALC_CYC - 1)) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (w_cfg_bad)    w_state_nxt = S_IDLE;
        else if (busy_in) w_state_nxt = S_WAIT_IDLE;
        else              w_state_nxt = S_APPLY;
      end
      S_WAIT_IDLE: if (!busy_in) w_state_nxt = S_APPLY;
      S_APPLY:     w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_num       <= '0;
      r_den       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_calc_cnt  <= '0;
      r_baud_zero <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_cfg_done  <= 1'b0;
      r_locked    <= 1'b0;
      r_divisor   <= '0;
    end else begin
      r_cfg_done <= 1'b0;
      case (r_state)
        S_IDLE: if (cfg_valid) begin
          r_num       <= w_num_init;
          r_den       <= w_den_init;
          r_rem       <= '0;
          r_quo       <= '0;
          r_calc_cnt  <= '0;
          r_baud_zero <= (cfg_baud == 32'd0);
          r_cfg_err   <= 1'b0;
        end
        S_CALC: begin
          r_num      <= r_num << 1;
          r_rem      <= w_ge ? w_diff : w_trial[AW-1:0];
          r_quo      <= {r_quo[AW-2:0], w_ge};
          r_calc_cnt <= r_calc_cnt + CNT_W'(1);
        end
        S_CHECK: if (w_cfg_bad) r_cfg_err <= 1'b1;
        S_APPLY: begin
          r_divisor  <= w_q_int[DIV_W-1:0];
          r_locked   <= 1'b1;
          r_cfg_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] r_frac;
  logic [FRAC_W-1:0] r_acc;
  logic              r_extend;

  // A carry out of the accumulator stretches the following os period by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frac   <= '0;
      r_acc    <= '0;
      r_extend <= 1'b0;
    end else if (r_state == S_APPLY) begin
      r_frac   <= w_q_frac;
      r_acc    <= '0;
      r_extend <= 1'b0;
    end else if (w_os_wrap) begin
      {r_extend, r_acc} <= {1'b0, r_acc} + {1'b0, r_frac};
    end
  end

  assign w_extend = r_extend;
`else
  assign w_extend = 1'b0;
`endif

  assign w_os_last = r_divisor - DIV_W'(1) + DIV_W'(w_extend);
  assign w_os_wrap = r_locked & (r_os_cnt == w_os_last);

  // Ticks are registered, so the first os_tick lands exactly one period after cfg_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_os_cnt    <= '0;
      r_phase     <= '0;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
    end else if (r_state == S_APPLY) begin
      r_os_cnt    <= '0;
      r_phase     <= '0;
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
    end else if (w_os_wrap) begin
      r_os_cnt    <= '0;
      r_phase     <= r_phase + OSR_LOG2'(1);
      r_os_tick   <= 1'b1;
      r_baud_tick <= &r_phase;
    end else begin
      if (r_locked) r_os_cnt <= r_os_cnt + DIV_W'(1);
      r_os_tick   <= 1'b0;
      r_baud_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Self-checking bench for uart_baud_ctrl: directed and randomized configs against an arithmetic tick-schedule model.
module tb_uart_baud_ctrl;
  localparam int OSR_LOG2 = 4;
  localparam int DIV_W    = 16;
  localparam int OSR      = 1 << OSR_LOG2;
  localparam int CALC_CYC = 36 + OSR_LOG2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [31:0]      cfg_baud = '0;
  logic [31:0]      cfg_clk_freq = '0;
  logic             busy_in = 1'b0;
  logic             cfg_done;
  logic             cfg_err;
  logic             locked;
  logic [DIV_W-1:0] divisor;
  logic             os_tick;
  logic             baud_tick;

  uart_baud_ctrl #(.OSR_LOG2(OSR_LOG2), .DIV_W(DIV_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_baud     (cfg_baud),
    .cfg_clk_freq (cfg_clk_freq),
    .busy_in      (busy_in),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .locked       (locked),
    .divisor      (divisor),
    .os_tick      (os_tick),
    .baud_tick    (baud_tick)
  );

  always #5 clk = ~clk;

  int     n_assert = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  // Reference model: expected state is derived from event cycles, not from RTL structure.
  bit     m_locked, m_err, m_calc_busy;
  longint m_div, m_t0, m_pend_div;
  longint m_xfer_cyc, m_err_cyc, m_apply_cyc;

  function automatic longint ref_q(input longint f, input longint b);
    if (b == 0) return 0;
    return (f + b * (OSR / 2)) / (b * OSR);
  endfunction

  task automatic reset_model();
    m_locked = 0; m_err = 0; m_calc_busy = 0;
    m_div = 0; m_t0 = 0; m_pend_div = 0;
    m_xfer_cyc = -1; m_err_cyc = -1; m_apply_cyc = -1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle();
    longint dt;
    bit     e_os, e_bd;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == m_xfer_cyc) begin m_calc_busy = 1; m_err = 0; end
    if (cyc == m_err_cyc) begin m_calc_busy = 0; m_err = 1; end
    if (cyc == m_apply_cyc) begin
      m_calc_busy = 0; m_locked = 1; m_div = m_pend_div; m_t0 = cyc;
    end
    dt   = cyc - m_t0;
    e_os = m_locked && dt > 0 && (dt % m_div) == 0;
    e_bd = e_os && ((dt / m_div) % OSR) == 0;
    check("os_tick",   os_tick,   e_os);
    check("baud_tick", baud_tick, e_bd);
    check("cfg_done",  cfg_done,  cyc == m_apply_cyc);
    check("cfg_ready", cfg_ready, !m_calc_busy);
    check("cfg_err",   cfg_err,   m_err);
    check("locked",    locked,    m_locked);
    check("divisor",   divisor,   m_div);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic send_cfg(input logic [31:0] f, input logic [31:0] b);
    longint q;
    int     budget = 0;
    while (cfg_ready !== 1'b1 && budget < 500) begin cycle(); budget++; end
    check("ready_wait", cfg_ready, 1'b1);
    cfg_valid    = 1'b1;
    cfg_clk_freq = f;
    cfg_baud     = b;
    q            = ref_q(longint'(f), longint'(b));
    m_xfer_cyc   = cyc + 1;
    m_pend_div   = q;
    if (b == 0 || q == 0 || q > (1 << DIV_W) - 1) begin
      m_err_cyc   = cyc + 1 + CALC_CYC + 1;
      m_apply_cyc = -1;
    end else begin
      m_err_cyc   = -1;
      m_apply_cyc = busy_in ? -1 : cyc + 1 + CALC_CYC + 2;
    end
    cycle();
    cfg_valid    = 1'b0;
    cfg_clk_freq = $urandom;
    cfg_baud     = $urandom;
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint b, d, f;
    reset_model();
    #1 rst = 1'b0;
    run(4);
    rst = 1'b1;
    run(2);

    // Directed: basic lock, then standard baud rates.
    send_cfg(32'd48, 32'd1);
    run(CALC_CYC + 1 + 100);
    send_cfg(32'd50_000_000, 32'd115200);
    run(CALC_CYC + 1 + 440);
    send_cfg(32'd16_000_000, 32'd9600);
    run(CALC_CYC + 1 + 220);

    // Rejected configs leave divisor and ticks running.
    send_cfg(32'd48_000, 32'd0);
    run(CALC_CYC + 20);
    send_cfg(32'd1000, 32'd115200);
    run(CALC_CYC + 20);
    send_cfg(32'hFFFF_FFFF, 32'd1);
    run(CALC_CYC + 20);
    send_cfg(32'd48, 32'd1);
    run(CALC_CYC + 1 + 60);

    // Apply held off by busy_in; cfg_valid in WAIT_IDLE is ignored.
    busy_in = 1'b1;
    run(3);
    send_cfg(32'd16_000_000, 32'd9600);
    run(CALC_CYC + 40);
    cfg_valid = 1'b1; cfg_clk_freq = 32'd48; cfg_baud = 32'd1;
    run(3);
    cfg_valid = 1'b0;
    run(20);
    busy_in = 1'b0;
    m_apply_cyc = cyc + 2;
    run(2 + 250);

    // Reset in the middle of the calculation.
    send_cfg(32'd48, 32'd1);
    run(10);
    rst = 1'b0;
    #1;
    check("rst_locked",  locked,    1'b0);
    check("rst_divisor", divisor,   '0);
    check("rst_ready",   cfg_ready, 1'b1);
    check("rst_os_tick", os_tick,   1'b0);
    check("rst_done",    cfg_done,  1'b0);
    check("rst_err",     cfg_err,   1'b0);
    reset_model();
    run(3);
    rst = 1'b1;
    run(3);
    send_cfg(32'd16_000_000, 32'd9600);
    run(CALC_CYC + 1 + 220);

    // Randomized valid configs, some held off by busy_in.
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(1, 40);
      b = $urandom_range(1200, 230400);
      f = b * OSR * d + $urandom_range(0, 32'(b * OSR - 1));
      if ($urandom_range(0, 1) == 1) begin
        busy_in = 1'b1;
        send_cfg(32'(f), 32'(b));
        run(CALC_CYC + 10);
        busy_in = 1'b0;
        m_apply_cyc = cyc + 2;
        run(2 + 16 * (d + 1) + 5);
      end else begin
        send_cfg(32'(f), 32'(b));
        run(CALC_CYC + 1 + 16 * (d + 1) + 5);
      end
    end

    // Randomized reject (quotient rounds to zero).
    b = $urandom_range(1000, 100000);
    f = $urandom_range(0, 32'(b * (OSR / 2) - 1));
    send_cfg(32'(f), 32'(b));
    run(CALC_CYC + 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
